// File: rtl/attn_seq_pkg.sv
// rtl/attn_seq_pkg.sv - shared types and inst field positions for the attention sequencer
package attn_seq_pkg;

    localparam int INST_W = 17;
    localparam int CNT_W  = 16;
    localparam int ADD_W  = 4;

    localparam int I_OFIFO_RD  = 16;
    localparam int I_QK_ADD    = 12;
    localparam int I_P_ADD     = 8;
    localparam int I_EXECUTE   = 7;
    localparam int I_LOAD      = 6;
    localparam int I_QMEM_RD   = 5;
    localparam int I_QMEM_WR   = 4;
    localparam int I_KMEM_RD   = 3;
    localparam int I_KMEM_WR   = 2;
    localparam int I_PMEM_RD   = 1;
    localparam int I_PMEM_WR   = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_QWR,
        S_KWR,
        S_GAP1,
        S_KLD,
        S_KLD_TAIL,
        S_GAP2,
        S_EXEC,
        S_GAP3,
        S_OMV,
        S_GAP4,
        S_ACC,
        S_SUMRD,
        S_DIV,
        S_DONE
    } state_t;

endpackage

// File: rtl/attn_phase_cnt.sv
// rtl/attn_phase_cnt.sv - loadable phase down-counter with terminal-count flag
module attn_phase_cnt
    import attn_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/attn_seq_ctrl.sv
// rtl/attn_seq_ctrl.sv - attention core sequencer; ATTN_SEQ_KREUSE_EN adds k_reuse to skip the K path
module attn_seq_ctrl
    import attn_seq_pkg::*;
#(
    parameter int bw          = 8,
    parameter int pr          = 16,
    parameter int col         = 8,
    parameter int total_cycle = 8,
    parameter int gap         = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
`ifdef ATTN_SEQ_KREUSE_EN
    input  logic                k_reuse,
`endif
    input  logic                wr_valid,
    input  logic [pr*bw-1:0]    wr_data,
    output logic                wr_ready,
    output logic [pr*bw-1:0]    mem_in,
    output logic [INST_W-1:0]   inst,
    output logic                acc,
    output logic                div,
    output logic                fifo_ext_rd,
    output logic                busy,
    output logic                done
);

    state_t             state, state_nxt;
    logic [4:0]         idx, idx_nxt, idx_m1;
    logic               kreuse_q;
    logic               accept, wr_phase, tc;
    logic [CNT_W-1:0]   load_val;
    logic [INST_W-1:0]  inst_nxt;
    logic [pr*bw-1:0]   mem_in_nxt;
    logic               acc_nxt, div_nxt, fifo_nxt;

    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            S_QWR, S_EXEC, S_OMV:       return CNT_W'(total_cycle);
            S_KWR:                      return CNT_W'(col);
            S_GAP1, S_GAP2,
            S_GAP3, S_GAP4:             return CNT_W'(gap);
            S_KLD:                      return CNT_W'(col + 1);
            S_KLD_TAIL:                 return CNT_W'(2);
            S_ACC, S_DIV:               return CNT_W'(total_cycle + 1);
            S_SUMRD:                    return CNT_W'(total_cycle + 2);
            default:                    return CNT_W'(1);
        endcase
    endfunction

    assign wr_phase = (state == S_QWR) || (state == S_KWR);
    assign accept   = wr_valid && wr_ready;
    assign load_val = phase_len(state_nxt) - CNT_W'(1);

    attn_phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state_nxt != state),
        .load_val (load_val),
        .dec      (wr_phase ? accept : 1'b1),
        .tc       (tc)
    );

`ifdef ATTN_SEQ_KREUSE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            kreuse_q <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            kreuse_q <= k_reuse;
        end
    end
`else
    assign kreuse_q = 1'b0;
`endif

    // Outputs are computed for the coming cycle so every strobe is a flop
    // aligned with its phase; write beats show up one cycle after acceptance.
    always_comb begin
        state_nxt  = state;
        inst_nxt   = '0;
        mem_in_nxt = mem_in;
        acc_nxt    = 1'b0;
        div_nxt    = 1'b0;
        fifo_nxt   = 1'b0;

        case (state)
            S_IDLE:     if (start) state_nxt = S_QWR;
            S_QWR:      if (accept && tc) state_nxt = kreuse_q ? S_GAP2 : S_KWR;
            S_KWR:      if (accept && tc) state_nxt = S_GAP1;
            S_GAP1:     if (tc) state_nxt = S_KLD;
            S_KLD:      if (tc) state_nxt = S_KLD_TAIL;
            S_KLD_TAIL: if (tc) state_nxt = S_GAP2;
            S_GAP2:     if (tc) state_nxt = S_EXEC;
            S_EXEC:     if (tc) state_nxt = S_GAP3;
            S_GAP3:     if (tc) state_nxt = S_OMV;
            S_OMV:      if (tc) state_nxt = S_GAP4;
            S_GAP4:     if (tc) state_nxt = S_ACC;
            S_ACC:      if (tc) state_nxt = S_SUMRD;
            S_SUMRD:    if (tc) state_nxt = S_DIV;
            S_DIV:      if (tc) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase

        if (state_nxt != state) begin
            idx_nxt = '0;
        end else if (wr_phase) begin
            idx_nxt = accept ? idx + 5'd1 : idx;
        end else begin
            idx_nxt = idx + 5'd1;
        end
        idx_m1 = idx_nxt - 5'd1;

        if (wr_phase && accept) begin
            inst_nxt[(state == S_QWR) ? I_QMEM_WR : I_KMEM_WR] = 1'b1;
            inst_nxt[I_QK_ADD +: ADD_W] = idx[ADD_W-1:0];
            mem_in_nxt = wr_data;
        end else begin
            case (state_nxt)
                S_QWR, S_KWR: inst_nxt[I_QK_ADD +: ADD_W] = inst[I_QK_ADD +: ADD_W];
                S_KLD: begin
                    inst_nxt[I_LOAD]    = 1'b1;
                    inst_nxt[I_KMEM_RD] = (idx_nxt != 5'd0);
                    inst_nxt[I_QK_ADD +: ADD_W] = (idx_nxt <= 5'd1) ? '0 : idx_m1[ADD_W-1:0];
                end
                S_KLD_TAIL: inst_nxt[I_LOAD] = (idx_nxt == 5'd0);
                S_EXEC: begin
                    inst_nxt[I_EXECUTE] = 1'b1;
                    inst_nxt[I_QMEM_RD] = 1'b1;
                    inst_nxt[I_QK_ADD +: ADD_W] = idx_nxt[ADD_W-1:0];
                end
                S_OMV: begin
                    inst_nxt[I_OFIFO_RD] = 1'b1;
                    inst_nxt[I_PMEM_WR]  = 1'b1;
                    inst_nxt[I_P_ADD +: ADD_W] = idx_nxt[ADD_W-1:0];
                end
                S_ACC: begin
                    acc_nxt = 1'b1;
                    inst_nxt[I_PMEM_RD] = 1'b1;
                    inst_nxt[I_P_ADD +: ADD_W] = idx_nxt[ADD_W-1:0];
                end
                S_SUMRD: fifo_nxt = 1'b1;
                S_DIV: begin
                    div_nxt = 1'b1;
                    inst_nxt[I_PMEM_RD] = 1'b1;
                    inst_nxt[I_P_ADD +: ADD_W] = (idx_nxt == 5'd0) ? '0 : idx_m1[ADD_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            inst        <= '0;
            mem_in      <= '0;
            acc         <= 1'b0;
            div         <= 1'b0;
            fifo_ext_rd <= 1'b0;
            wr_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            inst        <= inst_nxt;
            mem_in      <= mem_in_nxt;
            acc         <= acc_nxt;
            div         <= div_nxt;
            fifo_ext_rd <= fifo_nxt;
            wr_ready    <= (state_nxt == S_QWR) || (state_nxt == S_KWR);
            busy        <= (state_nxt != S_IDLE);
            done        <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// tb/tb_attn_seq_ctrl.sv - self-checking bench for attn_seq_ctrl against a phase-timeline model
module tb_attn_seq_ctrl;

    localparam int TC   = 8;
    localparam int COL  = 8;
    localparam int GAP  = 10;
    localparam int DW   = 128;
    localparam int MAXC = 512;

    localparam int B_OFIFO = 16;
    localparam int B_EXE   = 7;
    localparam int B_LOAD  = 6;
    localparam int B_QRD   = 5;
    localparam int B_QWR   = 4;
    localparam int B_KRD   = 3;
    localparam int B_KWR   = 2;
    localparam int B_PRD   = 1;
    localparam int B_PWR   = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          k_reuse = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [DW-1:0] mem_in;
    logic [16:0]   inst;
    logic          acc, div, fifo_ext_rd, busy, done;

    int n_err = 0;
    int n_chk = 0;

    logic [16:0]   exp_inst [MAXC];
    logic [5:0]    exp_flg  [MAXC];
    logic [DW-1:0] exp_mem  [MAXC];
    bit            ev       [MAXC];
    bit            vpat     [MAXC];
    logic [DW-1:0] beat_data[64];
    logic [DW-1:0] mem_hold = '0;
    int            n_beats, exec_start, done_cyc, w_cyc;

    attn_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef ATTN_SEQ_KREUSE_EN
        .k_reuse     (k_reuse),
`endif
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .mem_in      (mem_in),
        .inst        (inst),
        .acc         (acc),
        .div         (div),
        .fifo_ext_rd (fifo_ext_rd),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Expected per-cycle outputs; cycle 0 is the first cycle after start is sampled.
    // Flags are {acc, div, fifo_ext_rd, busy, done, wr_ready}.
    task automatic build(input bit kre);
        int t, n;
        logic [3:0]    last_add;
        logic [DW-1:0] prev;
        for (int k = 0; k < MAXC; k++) begin
            exp_inst[k] = '0; exp_flg[k] = '0; ev[k] = 1'b0;
        end
        n_beats = kre ? TC : TC + COL;
        for (int b = 0; b < n_beats; b++) beat_data[b] = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        w_cyc = 0;
        for (int c = 0; n < n_beats; c++) begin
            if (vpat[c]) begin
                exp_inst[c+1][(n < TC) ? B_QWR : B_KWR] = 1'b1;
                exp_inst[c+1][15:12] = 4'((n < TC) ? n : n - TC);
                exp_mem[c+1] = beat_data[n];
                ev[c+1] = 1'b1;
                n++;
                w_cyc = c + 1;
            end
        end
        last_add = '0;
        for (int k = 1; k < w_cyc; k++) begin
            if (ev[k]) last_add = exp_inst[k][15:12];
            else exp_inst[k][15:12] = last_add;
        end
        for (int k = 0; k < w_cyc; k++) exp_flg[k][0] = 1'b1;
        t = w_cyc;
        if (!kre) begin
            t += GAP;
            for (int j = 0; j <= COL; j++) begin
                exp_inst[t+j][B_LOAD] = 1'b1;
                exp_inst[t+j][B_KRD]  = (j >= 1);
                exp_inst[t+j][15:12]  = (j <= 1) ? 4'd0 : 4'(j - 1);
            end
            t += COL + 1;
            exp_inst[t][B_LOAD] = 1'b1;
            t += 2;
        end
        t += GAP;
        exec_start = t;
        for (int j = 0; j < TC; j++) begin
            exp_inst[t+j][B_EXE] = 1'b1; exp_inst[t+j][B_QRD] = 1'b1; exp_inst[t+j][15:12] = 4'(j);
        end
        t += TC + GAP;
        for (int j = 0; j < TC; j++) begin
            exp_inst[t+j][B_OFIFO] = 1'b1; exp_inst[t+j][B_PWR] = 1'b1; exp_inst[t+j][11:8] = 4'(j);
        end
        t += TC + GAP;
        for (int j = 0; j <= TC; j++) begin
            exp_flg[t+j][5] = 1'b1; exp_inst[t+j][B_PRD] = 1'b1; exp_inst[t+j][11:8] = 4'(j % 16);
        end
        t += TC + 1;
        for (int j = 0; j < TC + 2; j++) exp_flg[t+j][3] = 1'b1;
        t += TC + 2;
        for (int j = 0; j <= TC; j++) begin
            exp_flg[t+j][4] = 1'b1; exp_inst[t+j][B_PRD] = 1'b1;
            exp_inst[t+j][11:8] = (j == 0) ? 4'd0 : 4'(j - 1);
        end
        t += TC + 1;
        done_cyc = t;
        exp_flg[t][1] = 1'b1;
        for (int k = 0; k <= t; k++) exp_flg[k][2] = 1'b1;
        prev = mem_hold;
        for (int k = 0; k < MAXC; k++) begin
            if (ev[k]) prev = exp_mem[k];
            exp_mem[k] = prev;
        end
    endtask

    task automatic run_seq(input bit kre, input int rst_cyc, input bit noise, input string tag);
        int nd, last, nbusy, ndone, busy_exp;
        logic [22:0]   e_ctrl;
        logic [DW-1:0] e_mem;
        nd = 0; nbusy = 0; ndone = 0;
        last = (rst_cyc >= 0) ? rst_cyc + 3 : done_cyc + 3;
        @(negedge clk);
        start = 1'b1;
        k_reuse = kre;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            start = 1'b0;
            k_reuse = 1'($urandom_range(0, 1));
            if (rst_cyc >= 0 && k > rst_cyc) begin
                e_ctrl = '0; e_mem = '0;
            end else begin
                e_ctrl = {exp_inst[k], exp_flg[k]};
                e_mem = exp_mem[k];
            end
            n_chk++;
            assert ({inst, acc, div, fifo_ext_rd, busy, done, wr_ready} === e_ctrl) else begin
                n_err++;
                $error("FAIL %s ctrl cyc=%0d obs=%h exp=%h", tag, k,
                       {inst, acc, div, fifo_ext_rd, busy, done, wr_ready}, e_ctrl);
            end
            n_chk++;
            assert (mem_in === e_mem) else begin
                n_err++;
                $error("FAIL %s mem_in cyc=%0d obs=%h exp=%h", tag, k, mem_in, e_mem);
            end
            if (busy) nbusy++;
            if (done) ndone++;
            if (nd < n_beats && vpat[k]) begin
                wr_valid = 1'b1;
                wr_data = beat_data[nd];
                nd++;
            end else begin
                wr_valid = (noise && nd >= n_beats) ? 1'($urandom_range(0, 1)) : 1'b0;
                wr_data = {$urandom, $urandom, $urandom, $urandom};
            end
            if (noise && (k == 5 || k == exec_start)) start = 1'b1;
            reset = (k == rst_cyc) ? 1'b0 : 1'b1;
        end
        start = 1'b0;
        wr_valid = 1'b0;
        if (rst_cyc < 0) begin
            busy_exp = w_cyc + (kre ? 3 * GAP : 4 * GAP + (COL + 1) + 2)
                     + TC + TC + (TC + 1) + (TC + 2) + (TC + 1) + 1;
            n_chk++;
            assert (nbusy === busy_exp) else begin
                n_err++;
                $error("FAIL %s busy_len obs=%0d exp=%0d", tag, nbusy, busy_exp);
            end
            mem_hold = exp_mem[last];
        end else begin
            mem_hold = '0;
        end
        n_chk++;
        assert (ndone === ((rst_cyc < 0) ? 1 : 0)) else begin
            n_err++;
            $error("FAIL %s done_cnt obs=%0d exp=%0d", tag, ndone, (rst_cyc < 0) ? 1 : 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        assert ({inst, acc, div, fifo_ext_rd, busy, done, wr_ready} === 23'd0) else begin
            n_err++;
            $error("FAIL reset_ctrl obs=%h exp=0", {inst, acc, div, fifo_ext_rd, busy, done, wr_ready});
        end
        n_chk++;
        assert (mem_in === '0) else begin
            n_err++;
            $error("FAIL reset_mem obs=%h exp=0", mem_in);
        end
        reset = 1'b1;
        @(negedge clk);

        for (int c = 0; c < MAXC; c++) vpat[c] = 1'b1;
        build(1'b0);
        run_seq(1'b0, -1, 1'b0, "cont");

        for (int c = 0; c < MAXC; c++) vpat[c] = (c % 2 == 0);
        build(1'b0);
        run_seq(1'b0, -1, 1'b0, "toggle");

        for (int c = 0; c < MAXC; c++) vpat[c] = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
        build(1'b0);
        run_seq(1'b0, -1, 1'b1, "rand");

        for (int c = 0; c < MAXC; c++) vpat[c] = 1'b1;
        build(1'b0);
        run_seq(1'b0, exec_start + 3, 1'b0, "reset");

        build(1'b0);
        run_seq(1'b0, -1, 1'b0, "post_rst");

`ifdef ATTN_SEQ_KREUSE_EN
        for (int c = 0; c < MAXC; c++) vpat[c] = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        build(1'b1);
        run_seq(1'b1, -1, 1'b0, "kreuse");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
